// File: rtl/stepper_spi_master_if.sv
// Command/response and SPI pin bundle for stepper_spi_master.
//   master modport: the SPI host (takes commands, drives SCLK/MOSI/CS_N, returns responses)
//   slave modport : the requester plus the SPI target (issues commands, drives MISO)
// Signals:
//   cmd_valid/cmd_ready     command handshake, accepted when both are high
//   cmd_rw/addr/wdata       command payload (rw=1 is a write)
//   rsp_valid/rsp_rdata     one-cycle completion pulse and the 32 captured MISO bits
//   busy                    transaction in progress
//   spi_sclk/mosi/miso/cs_n SPI mode 0 pins
interface stepper_spi_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_miso,
        output cmd_ready, rsp_valid, rsp_rdata, busy, spi_sclk, spi_mosi, spi_cs_n
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_miso,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_sclk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/stepper_spi_master.sv
// SPI mode 0 host for the stepper driver register file. One 40-bit transaction per
// command: address byte {rw, addr[6:0]} then 32 data bits, MSB first. The last 32 bits
// sampled on MISO are returned with a single-cycle rsp_valid pulse.
// Parameters:
//   CLK_DIV  clk cycles per SCLK half-period (2..255)
//   CS_GAP   minimum clk cycles CS_N stays high between transactions (>= 1)
// Ports:
//   clk, rst  system clock; synchronous active-high reset
//   bus       stepper_spi_master_if.master (command, response and SPI pins)
module stepper_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input logic                  clk,
    input logic                  rst,
    stepper_spi_master_if.master bus
);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_clk_div_check
        $error("stepper_spi_master: CLK_DIV must be within 2..255");
    end
    if (CS_GAP < 1) begin : g_cs_gap_check
        $error("stepper_spi_master: CS_GAP must be at least 1");
    end

    localparam int unsigned GapW    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;         // cycles within SETUP / HOLD / one SCLK phase
    logic [GapW-1:0] gap_q, gap_d;
    logic [5:0]      bit_q, bit_d;         // 0..39, never wraps
    logic            low_q, low_d;         // SHIFT: 0 = SCLK high phase, 1 = low phase
    logic [39:0]     shreg_q, shreg_d;
    logic [31:0]     rx_q, rx_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            miso_meta_q, miso_sync_q;
    logic            active_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            gap_q       <= '0;
            bit_q       <= '0;
            low_q       <= 1'b0;
            shreg_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            bit_q       <= bit_d;
            low_q       <= low_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            miso_meta_q <= bus.spi_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        bit_d       = bit_q;
        low_d       = low_q;
        shreg_d     = shreg_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                    bit_d   = '0;
                    low_d   = 1'b0;
                    shreg_d = {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
                end
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    low_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StShift: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    if (!low_q) begin
                        // End of high phase: sample MISO, and advance MOSI with the falling SCLK.
                        rx_d    = {rx_q[30:0], miso_sync_q};
                        shreg_d = {shreg_q[38:0], 1'b0};
                        low_d   = 1'b1;
                    end else if (bit_q == 6'd39) begin
                        state_d = StHold;
                    end else begin
                        bit_d = bit_q + 6'd1;
                        low_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (cnt_q == DivLast) begin
                    state_d     = StGap;
                    gap_d       = '0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = rx_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pin values are computed from the next state so the pins themselves are flops.
        active_d = (state_d == StSetup) || (state_d == StShift) || (state_d == StHold);
        cs_n_d   = !active_d;
        sclk_d   = (state_d == StShift) && !low_d;
        mosi_d   = active_d && shreg_d[39];
    end

    // Reset takes effect on the pins in the same cycle it is asserted.
    assign bus.spi_cs_n  = cs_n_q | rst;
    assign bus.spi_sclk  = sclk_q & ~rst;
    assign bus.spi_mosi  = mosi_q & ~rst;
    assign bus.rsp_valid = rsp_valid_q & ~rst;
    assign bus.rsp_rdata = rst ? 32'd0 : rdata_q;
    assign bus.busy      = (state_q != StIdle) & ~rst;
    assign bus.cmd_ready = (state_q == StIdle) & ~rst;

endmodule

// File: tb/tb_stepper_spi_master.sv
// Directed bench for stepper_spi_master: a CLK_DIV=4/CS_GAP=4 instance with an ideal
// mode-0 slave, and a CLK_DIV=2/CS_GAP=1 instance whose slave updates MISO late.
module tb_stepper_spi_master;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CS_GAP  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stepper_spi_master_if bus ();
    stepper_spi_master_if bus2 ();

    stepper_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    stepper_spi_master #(.CLK_DIV(2), .CS_GAP(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + ideal slave for dut (everything sampled mid-cycle on negedge).
    logic [39:0] slv_word;
    logic [39:0] slv_sh = '0;
    logic [39:0] mosi_cap = '0;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;
    int rises = 0, cs_low = 0, cs_high_run = 0, last_gap = 0;
    int rsp_cnt = 0, rsp_cyc = 0, acc_cnt = 0, acc_cyc = 0;

    always @(negedge clk) begin
        if (rst) bus.spi_miso = 1'b0;
        if (!bus.spi_cs_n && cs_prev) begin
            slv_sh       = slv_word;
            bus.spi_miso = slv_sh[39];
            last_gap     = cs_high_run;
        end
        if (bus.spi_sclk && !sclk_prev) begin
            mosi_cap = {mosi_cap[38:0], bus.spi_mosi};
            rises++;
        end
        if (!bus.spi_sclk && sclk_prev && !bus.spi_cs_n) begin
            slv_sh       = {slv_sh[38:0], 1'b0};
            bus.spi_miso = slv_sh[39];
        end
        if (bus.spi_cs_n) begin
            cs_high_run++;
        end else begin
            cs_low++;
            cs_high_run = 0;
        end
        if (bus.rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        sclk_prev = bus.spi_sclk;
        cs_prev   = bus.spi_cs_n;
    end

    // Slave for dut2: MISO settles 1.5 clk cycles after SCLK falls, the latest point that
    // the 2-FF synchronizer can still deliver before the end of the next high phase.
    logic [39:0] slv2_word;
    logic [39:0] slv2_sh = '0;
    logic        sclk2_prev = 1'b0;
    logic        cs2_prev = 1'b1;
    logic        miso2_next = 1'b0;
    logic        miso2_pend = 1'b0;
    int rsp2_cnt = 0, rsp2_cyc = 0, acc2_cyc = 0;

    always @(negedge clk) begin
        if (rst) bus2.spi_miso = 1'b0;
        if (miso2_pend) begin
            bus2.spi_miso = miso2_next;
            miso2_pend    = 1'b0;
        end
        if (!bus2.spi_cs_n && cs2_prev) begin
            slv2_sh       = slv2_word;
            bus2.spi_miso = slv2_sh[39];
        end
        if (!bus2.spi_sclk && sclk2_prev && !bus2.spi_cs_n) begin
            slv2_sh    = {slv2_sh[38:0], 1'b0};
            miso2_next = slv2_sh[39];
            miso2_pend = 1'b1;
        end
        if (bus2.rsp_valid) begin
            rsp2_cnt++;
            rsp2_cyc = cyc;
        end
        if (bus2.cmd_valid && bus2.cmd_ready) acc2_cyc = cyc;
        sclk2_prev = bus2.spi_sclk;
        cs2_prev   = bus2.spi_cs_n;
    end

    // Issue one command on dut, wait for its response and for cmd_ready to return.
    task automatic run_cmd(input logic rw, input logic [6:0] addr, input logic [31:0] wdata);
        int base, w;
        base = rsp_cnt;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 1000) begin next_cycle(); w++; end
        next_cycle();
        bus.cmd_valid = 1'b0;
        w = 0;
        while (rsp_cnt == base && w < 1000) begin next_cycle(); w++; end
        check_eq("rsp_seen", 64'(rsp_cnt != base), 64'd1);
        w = 0;
        while (!bus.cmd_ready && w < 100) begin next_cycle(); w++; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int r0, c0, q0, a0, t_first, w, bad;
        rst = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_rw     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus2.cmd_valid = 1'b0;
        bus2.cmd_rw    = 1'b0;
        bus2.cmd_addr  = '0;
        bus2.cmd_wdata = '0;
        slv_word  = '0;
        slv2_word = '0;
        repeat (3) next_cycle();

        // Reset values
        check_eq("rst_cs_n", 64'(bus.spi_cs_n), 64'd1);
        check_eq("rst_sclk", 64'(bus.spi_sclk), 64'd0);
        check_eq("rst_mosi", 64'(bus.spi_mosi), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b0;
        next_cycle();
        check_eq("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
        check_eq("post_rst_busy", 64'(bus.busy), 64'd0);

        // 1: write addr 0, data 3
        slv_word = {8'h00, 32'h1357_9BDF};
        r0 = rises; c0 = cs_low; q0 = rsp_cnt;
        run_cmd(1'b1, 7'h00, 32'h0000_0003);
        check_eq("t1_mosi", 64'(mosi_cap), 64'h80_0000_0003);
        check_eq("t1_rises", 64'(rises - r0), 64'd40);
        check_eq("t1_cs_low", 64'(cs_low - c0), 64'd328);
        check_eq("t1_rsp_cnt", 64'(rsp_cnt - q0), 64'd1);
        check_eq("t1_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd329);
        check_eq("t1_rdata", 64'(bus.rsp_rdata), 64'h1357_9BDF);

        // 2: read addr 3
        slv_word = {8'hFF, 32'h0023_CA52};
        run_cmd(1'b0, 7'h03, 32'hFFFF_FFFF);
        check_eq("t2_rdata", 64'(bus.rsp_rdata), 64'h0023_CA52);
        check_eq("t2_addr_byte", 64'(mosi_cap[39:32]), 64'h03);
        check_eq("t2_mosi_data", 64'(mosi_cap[31:0]), 64'hFFFF_FFFF);

        // 3: cmd_valid held high across two commands
        a0 = acc_cnt; q0 = rsp_cnt;
        bus.cmd_rw    = 1'b1;
        bus.cmd_addr  = 7'h01;
        bus.cmd_wdata = 32'h1111_1111;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (acc_cnt == a0 && w < 1000) begin next_cycle(); w++; end
        t_first = acc_cyc;
        bus.cmd_addr  = 7'h02;
        bus.cmd_wdata = 32'h2222_2222;
        w = 0;
        while (acc_cnt < a0 + 2 && w < 1000) begin next_cycle(); w++; end
        bus.cmd_valid = 1'b0;
        check_eq("t3_accepts", 64'(acc_cnt - a0), 64'd2);
        check_eq("t3_spacing", 64'(acc_cyc - t_first), 64'(1 + CLK_DIV * 82 + CS_GAP));
        w = 0;
        while (rsp_cnt < q0 + 2 && w < 1000) begin next_cycle(); w++; end
        check_eq("t3_rsp_cnt", 64'(rsp_cnt - q0), 64'd2);
        check_eq("t3_cs_gap", 64'(last_gap >= CS_GAP), 64'd1);
        check_eq("t3_mosi2", 64'(mosi_cap), 64'h82_2222_2222);
        w = 0;
        while (!bus.cmd_ready && w < 100) begin next_cycle(); w++; end

        // 4: reset during bit 17 of SHIFT
        r0 = rises; q0 = rsp_cnt;
        bus.cmd_rw    = 1'b1;
        bus.cmd_addr  = 7'h05;
        bus.cmd_wdata = 32'hCAFE_F00D;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.busy && w < 100) begin next_cycle(); w++; end
        bus.cmd_valid = 1'b0;
        w = 0;
        while (rises - r0 < 18 && w < 1000) begin next_cycle(); w++; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t4_cs_n", 64'(bus.spi_cs_n), 64'd1);
        check_eq("t4_sclk", 64'(bus.spi_sclk), 64'd0);
        check_eq("t4_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("t4_rdata_cleared", 64'(bus.rsp_rdata), 64'd0);
        check_eq("t4_busy", 64'(bus.busy), 64'd0);
        #1;
        rst = 1'b0;
        repeat (40) next_cycle();
        check_eq("t4_no_rsp", 64'(rsp_cnt - q0), 64'd0);
        check_eq("t4_rises", 64'(rises - r0), 64'd18);
        check_eq("t4_ready", 64'(bus.cmd_ready), 64'd1);
        slv_word = {8'h00, 32'h600D_D00D};
        run_cmd(1'b0, 7'h02, 32'h0000_0000);
        check_eq("t4_after_rdata", 64'(bus.rsp_rdata), 64'h600D_D00D);
        check_eq("t4_after_mosi", 64'(mosi_cap), 64'h02_0000_0000);
        check_eq("t4_after_rsp_cnt", 64'(rsp_cnt - q0), 64'd1);

        // 5: cmd inputs wiggle while the transaction is in flight
        q0 = rsp_cnt;
        bus.cmd_rw    = 1'b1;
        bus.cmd_addr  = 7'h15;
        bus.cmd_wdata = 32'hC35A_0FF0;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.busy && w < 100) begin next_cycle(); w++; end
        w = 0;
        bad = 0;
        while (rsp_cnt == q0 && w < 1000) begin
            if (!bus.busy || bus.cmd_ready) bad++;
            bus.cmd_valid = ~bus.cmd_valid;
            bus.cmd_rw    = ~bus.cmd_rw;
            bus.cmd_addr  = 7'(w);
            bus.cmd_wdata = $urandom;
            next_cycle();
            w++;
        end
        bus.cmd_valid = 1'b0;
        check_eq("t5_busy_ready", 64'(bad), 64'd0);
        check_eq("t5_rsp_cnt", 64'(rsp_cnt - q0), 64'd1);
        check_eq("t5_mosi", 64'(mosi_cap), 64'h95_C35A_0FF0);
        w = 0;
        while (!bus.cmd_ready && w < 100) begin next_cycle(); w++; end

        // 6: CLK_DIV=2 with a late MISO
        slv2_word = {8'h00, 32'hA5A5_A5A5};
        q0 = rsp2_cnt;
        bus2.cmd_rw    = 1'b0;
        bus2.cmd_addr  = 7'h03;
        bus2.cmd_wdata = 32'h0;
        bus2.cmd_valid = 1'b1;
        w = 0;
        while (!bus2.cmd_ready && w < 100) begin next_cycle(); w++; end
        next_cycle();
        bus2.cmd_valid = 1'b0;
        w = 0;
        while (rsp2_cnt == q0 && w < 1000) begin next_cycle(); w++; end
        check_eq("t6_rsp_cnt", 64'(rsp2_cnt - q0), 64'd1);
        check_eq("t6_rdata", 64'(bus2.rsp_rdata), 64'hA5A5_A5A5);
        check_eq("t6_rsp_latency", 64'(rsp2_cyc - acc2_cyc), 64'd165);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
